// File: rtl/host_xfer_ctrl_pkg.sv
// Shared types and default limits for the host transfer controller.
package host_xfer_ctrl_pkg;

    localparam int unsigned DefMaxXfer        = 4096;
    localparam int unsigned DefMaxOutstanding = 8;
    localparam int unsigned DefVaddrBits      = 48;
    localparam int unsigned DefLenBits        = 28;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } xfer_state_t;

    typedef struct packed {
        logic [DefVaddrBits-1:0] vaddr;
        logic [DefLenBits-1:0]   len;
        logic                    last;
    } xfer_req_t;

endpackage

// File: rtl/host_xfer_out_cnt.sv
// Outstanding-request counter: same-cycle inc/dec, full flag, underflow pulse.
module host_xfer_out_cnt #(
    parameter int unsigned MAX_COUNT = 8,
    parameter int unsigned CNT_BITS  = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                underflow
);

    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc) begin
            // A completion with nothing in flight is an error; hold at zero.
            if (count_q == '0) begin
                underflow = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q >= CNT_BITS'(MAX_COUNT));

endmodule

// File: rtl/host_xfer_ctrl.sv
// Splits a host transfer into chunked sq_rd/sq_wr requests and tracks completions.
// Optional HOST_XFER_STATS_EN adds cycle_cnt and req_cnt statistics outputs.
module host_xfer_ctrl
    import host_xfer_ctrl_pkg::*;
#(
    parameter int unsigned VADDR_BITS      = DefVaddrBits,
    parameter int unsigned LEN_BITS        = DefLenBits,
    parameter int unsigned MAX_XFER        = DefMaxXfer,
    parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding,
    parameter int unsigned CNT_BITS        = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [VADDR_BITS-1:0] src_vaddr,
    input  logic [VADDR_BITS-1:0] dst_vaddr,
    input  logic [LEN_BITS-1:0]   total_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  sq_rd_valid,
    input  logic                  sq_rd_ready,
    output logic [VADDR_BITS-1:0] sq_rd_vaddr,
    output logic [LEN_BITS-1:0]   sq_rd_len,
    output logic                  sq_rd_last,
    output logic                  sq_wr_valid,
    input  logic                  sq_wr_ready,
    output logic [VADDR_BITS-1:0] sq_wr_vaddr,
    output logic [LEN_BITS-1:0]   sq_wr_len,
    output logic                  sq_wr_last,
    input  logic                  cq_rd_valid,
`ifdef HOST_XFER_STATS_EN
    output logic [31:0]           cycle_cnt,
    output logic [15:0]           req_cnt,
`endif
    input  logic                  cq_wr_valid
);

    localparam logic [LEN_BITS-1:0] MaxXferLen = LEN_BITS'(MAX_XFER);

    xfer_state_t           state_q, state_d;
    logic [VADDR_BITS-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [LEN_BITS-1:0]   remaining_q, remaining_d, chunk_len;
    logic                  rd_acc_q, rd_acc_d, wr_acc_q, wr_acc_d;
    logic                  chunk_last, in_issue, rd_hs, wr_hs;
    logic                  rd_full, wr_full, rd_uf, wr_uf, err_q;
    logic [CNT_BITS-1:0]   rd_out, wr_out;

    assign in_issue   = (state_q == StIssue);
    assign chunk_last = (remaining_q <= MaxXferLen);
    assign chunk_len  = chunk_last ? remaining_q : MaxXferLen;

    // Valid depends only on registered state, never on ready.
    assign sq_rd_valid = in_issue && !rd_acc_q && !rd_full;
    assign sq_wr_valid = in_issue && !wr_acc_q && !wr_full;
    assign rd_hs       = sq_rd_valid && sq_rd_ready;
    assign wr_hs       = sq_wr_valid && sq_wr_ready;

    assign sq_rd_vaddr = src_ptr_q;
    assign sq_rd_len   = chunk_len;
    assign sq_rd_last  = in_issue && chunk_last;
    assign sq_wr_vaddr = dst_ptr_q;
    assign sq_wr_len   = chunk_len;
    assign sq_wr_last  = in_issue && chunk_last;

    assign busy = (state_q != StIdle);
    assign err  = err_q;

    host_xfer_out_cnt #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_BITS  (CNT_BITS)
    ) u_rd_cnt (
        .aclk      (aclk),
        .areset    (areset),
        .inc       (rd_hs),
        .dec       (cq_rd_valid),
        .count     (rd_out),
        .full      (rd_full),
        .underflow (rd_uf)
    );

    host_xfer_out_cnt #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_BITS  (CNT_BITS)
    ) u_wr_cnt (
        .aclk      (aclk),
        .areset    (areset),
        .inc       (wr_hs),
        .dec       (cq_wr_valid),
        .count     (wr_out),
        .full      (wr_full),
        .underflow (wr_uf)
    );

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        rd_acc_d    = rd_acc_q;
        wr_acc_d    = wr_acc_q;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d   = src_vaddr;
                    dst_ptr_d   = dst_vaddr;
                    remaining_d = total_len;
                    state_d     = (total_len == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                rd_acc_d = rd_acc_q | rd_hs;
                wr_acc_d = wr_acc_q | wr_hs;
                // Advance only once both sides have taken this chunk.
                if (rd_acc_d && wr_acc_d) begin
                    src_ptr_d   = src_ptr_q + VADDR_BITS'(chunk_len);
                    dst_ptr_d   = dst_ptr_q + VADDR_BITS'(chunk_len);
                    remaining_d = remaining_q - chunk_len;
                    rd_acc_d    = 1'b0;
                    wr_acc_d    = 1'b0;
                    if (chunk_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (rd_out == '0 && wr_out == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            rd_acc_q    <= 1'b0;
            wr_acc_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            rd_acc_q    <= rd_acc_d;
            wr_acc_q    <= wr_acc_d;
            if (rd_uf || wr_uf) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef HOST_XFER_STATS_EN
    logic [31:0] cycle_cnt_q;
    logic [15:0] req_cnt_q;
    logic        chunk_done;

    assign chunk_done = in_issue && (rd_acc_q || rd_hs) && (wr_acc_q || wr_hs);

    always_ff @(posedge aclk) begin
        if (areset) begin
            cycle_cnt_q <= '0;
            req_cnt_q   <= '0;
        end else if (state_q == StIdle && start) begin
            cycle_cnt_q <= '0;
            req_cnt_q   <= '0;
        end else if (busy) begin
            if (cycle_cnt_q != '1) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (chunk_done && req_cnt_q != '1) begin
                req_cnt_q <= req_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign req_cnt   = req_cnt_q;
`endif

endmodule

// File: tb/tb_host_xfer_ctrl.sv
// Randomized self-checking bench for host_xfer_ctrl against a chunk-list reference model.
module tb_host_xfer_ctrl;

    localparam int MX = 4096;
    localparam int MO = 8;

    logic        aclk = 1'b0;
    logic        areset, start;
    logic [47:0] src_vaddr, dst_vaddr;
    logic [27:0] total_len;
    logic        busy, done, err;
    logic        sq_rd_valid, sq_rd_ready, sq_rd_last;
    logic [47:0] sq_rd_vaddr;
    logic [27:0] sq_rd_len;
    logic        sq_wr_valid, sq_wr_ready, sq_wr_last;
    logic [47:0] sq_wr_vaddr;
    logic [27:0] sq_wr_len;
    logic        cq_rd_valid, cq_wr_valid;
`ifdef HOST_XFER_STATS_EN
    logic [31:0] cycle_cnt;
    logic [15:0] req_cnt;
`endif

    host_xfer_ctrl #(
        .VADDR_BITS      (48),
        .LEN_BITS        (28),
        .MAX_XFER        (4096),
        .MAX_OUTSTANDING (8),
        .CNT_BITS        (4)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .start       (start),
        .src_vaddr   (src_vaddr),
        .dst_vaddr   (dst_vaddr),
        .total_len   (total_len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sq_rd_valid (sq_rd_valid),
        .sq_rd_ready (sq_rd_ready),
        .sq_rd_vaddr (sq_rd_vaddr),
        .sq_rd_len   (sq_rd_len),
        .sq_rd_last  (sq_rd_last),
        .sq_wr_valid (sq_wr_valid),
        .sq_wr_ready (sq_wr_ready),
        .sq_wr_vaddr (sq_wr_vaddr),
        .sq_wr_len   (sq_wr_len),
        .sq_wr_last  (sq_wr_last),
        .cq_rd_valid (cq_rd_valid),
`ifdef HOST_XFER_STATS_EN
        .cycle_cnt   (cycle_cnt),
        .req_cnt     (req_cnt),
`endif
        .cq_wr_valid (cq_wr_valid)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [47:0] a;
        logic [27:0] l;
        logic        last;
    } req_t;

    req_t        rq[$];
    req_t        wq[$];
    int          checks = 0;
    int          errors = 0;
    int          m_rd_out, m_wr_out, rd_iss, wr_iss, done_cnt;
    int          rp, wp, cp;
    bit          cq_en, force_rd, start_req, rd_pend, wr_pend;
    logic [47:0] n_src, n_dst;
    logic [27:0] n_len;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected request list: consecutive chunks of at most MX bytes.
    task automatic build_model(input logic [47:0] s, input logic [47:0] d, input logic [27:0] len);
        longint      rem;
        logic [47:0] a, b;
        int          c;
        req_t        r;
        rq.delete();
        wq.delete();
        rem = longint'(len);
        a   = s;
        b   = d;
        while (rem > 0) begin
            c      = (rem > MX) ? MX : int'(rem);
            r.l    = 28'(c);
            r.last = (rem <= MX);
            r.a    = a;
            rq.push_back(r);
            r.a    = b;
            wq.push_back(r);
            a      = a + 48'(c);
            b      = b + 48'(c);
            rem    = rem - c;
        end
    endtask

    task automatic step();
        @(negedge aclk);
        start = start_req;
        if (start_req) begin
            src_vaddr = n_src;
            dst_vaddr = n_dst;
            total_len = n_len;
        end
        start_req   = 1'b0;
        sq_rd_ready = ($urandom_range(99) < rp);
        sq_wr_ready = ($urandom_range(99) < wp);
        cq_rd_valid = force_rd || (cq_en && m_rd_out > 0 && $urandom_range(99) < cp);
        cq_wr_valid = cq_en && m_wr_out > 0 && ($urandom_range(99) < cp);
        force_rd    = 1'b0;
        #1;
        if (rd_pend) check_eq("rd_valid_hold", 64'(sq_rd_valid), 64'(1));
        if (wr_pend) check_eq("wr_valid_hold", 64'(sq_wr_valid), 64'(1));
        if (sq_rd_valid) begin
            check_eq("rd_limit", 64'(m_rd_out < MO), 64'(1));
            if (rq.size() == 0) begin
                check_eq("rd_spurious_valid", 64'(sq_rd_valid), 64'(0));
            end else begin
                check_eq("rd_vaddr", 64'(sq_rd_vaddr), 64'(rq[0].a));
                check_eq("rd_len", 64'(sq_rd_len), 64'(rq[0].l));
                check_eq("rd_last", 64'(sq_rd_last), 64'(rq[0].last));
                if (sq_rd_ready) begin
                    void'(rq.pop_front());
                    rd_iss++;
                    m_rd_out++;
                    check_eq("rd_ahead_of_wr", 64'(rd_iss <= wr_iss + 1), 64'(1));
                end
            end
        end
        if (sq_wr_valid) begin
            check_eq("wr_limit", 64'(m_wr_out < MO), 64'(1));
            if (wq.size() == 0) begin
                check_eq("wr_spurious_valid", 64'(sq_wr_valid), 64'(0));
            end else begin
                check_eq("wr_vaddr", 64'(sq_wr_vaddr), 64'(wq[0].a));
                check_eq("wr_len", 64'(sq_wr_len), 64'(wq[0].l));
                check_eq("wr_last", 64'(sq_wr_last), 64'(wq[0].last));
                if (sq_wr_ready) begin
                    void'(wq.pop_front());
                    wr_iss++;
                    m_wr_out++;
                    check_eq("wr_ahead_of_rd", 64'(wr_iss <= rd_iss + 1), 64'(1));
                end
            end
        end
        rd_pend = sq_rd_valid && !sq_rd_ready;
        wr_pend = sq_wr_valid && !sq_wr_ready;
        if (cq_rd_valid && m_rd_out > 0) m_rd_out--;
        if (cq_wr_valid && m_wr_out > 0) m_wr_out--;
        if (done) begin
            done_cnt++;
            check_eq("done_rd_left", 64'(rq.size() + m_rd_out), 64'(0));
            check_eq("done_wr_left", 64'(wq.size() + m_wr_out), 64'(0));
            check_eq("busy_at_done", 64'(busy), 64'(1));
        end
    endtask

    task automatic begin_xfer(input logic [47:0] s, input logic [47:0] d, input logic [27:0] len,
                              input int rp_i, input int wp_i, input int cp_i, input bit en);
        build_model(s, d, len);
        n_src     = s;
        n_dst     = d;
        n_len     = len;
        rp        = rp_i;
        wp        = wp_i;
        cp        = cp_i;
        cq_en     = en;
        rd_iss    = 0;
        wr_iss    = 0;
        done_cnt  = 0;
        start_req = 1'b1;
        step();
        step();
        if (len != 0) begin
            check_eq("start_to_valid", 64'(sq_rd_valid && sq_wr_valid), 64'(1));
        end else begin
            step();
            check_eq("zero_len_done", 64'(done_cnt), 64'(1));
            check_eq("zero_len_no_req", 64'(rd_iss + wr_iss), 64'(0));
        end
    endtask

    task automatic finish_xfer(input int exp_chunks);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) step();
        check_eq("done_seen", 64'(done_cnt), 64'(1));
        check_eq("chunks_rd", 64'(rd_iss), 64'(exp_chunks));
        check_eq("chunks_wr", 64'(wr_iss), 64'(exp_chunks));
        for (int i = 0; i < 3; i++) step();
        check_eq("done_once", 64'(done_cnt), 64'(1));
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("no_err", 64'(err), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset      = 1'b1;
        start       = 1'b0;
        sq_rd_ready = 1'b0;
        sq_wr_ready = 1'b0;
        cq_rd_valid = 1'b0;
        cq_wr_valid = 1'b0;
        @(negedge aclk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_valids", 64'({sq_rd_valid, sq_wr_valid}), 64'(0));
        check_eq("rst_last", 64'({sq_rd_last, sq_wr_last}), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        areset   = 1'b0;
        rq.delete();
        wq.delete();
        m_rd_out = 0;
        m_wr_out = 0;
        rd_pend  = 1'b0;
        wr_pend  = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t;
        logic [47:0] s, d, near_wrap;
        int          len, nchunks;
        areset = 1'b1;
        start = 1'b0;
        src_vaddr = '0;
        dst_vaddr = '0;
        total_len = '0;
        sq_rd_ready = 1'b0;
        sq_wr_ready = 1'b0;
        cq_rd_valid = 1'b0;
        cq_wr_valid = 1'b0;
        m_rd_out = 0;
        m_wr_out = 0;
        repeat (3) @(negedge aclk);
        #1;
        check_eq("reset_outs", 64'({busy, done, err, sq_rd_valid, sq_wr_valid,
                                    sq_rd_last, sq_wr_last}), 64'(0));
        check_eq("reset_fields", 64'(sq_rd_vaddr | sq_wr_vaddr | 48'(sq_rd_len | sq_wr_len)),
                 64'(0));
        areset = 1'b0;

        // Single chunk; completions only after a few cycles.
        begin_xfer(48'h1000, 48'h8000, 28'd100, 100, 100, 100, 1'b0);
        for (int i = 0; i < 4; i++) step();
        cq_en = 1'b1;
        finish_xfer(1);

        // Multi-chunk with a short final chunk.
        begin_xfer(48'h1000, 48'h8000, 28'd10000, 100, 100, 50, 1'b1);
        finish_xfer(3);

        // Write backpressure: read of chunk 2 must wait for write of chunk 1.
        begin_xfer(48'h4000, 48'h20000, 28'd10000, 100, 0, 50, 1'b1);
        for (int i = 0; i < 7; i++) step();
        check_eq("bp_rd_iss", 64'(rd_iss), 64'(1));
        check_eq("bp_wr_iss", 64'(wr_iss), 64'(0));
        wp = 100;
        finish_xfer(3);

        // Outstanding limit: no completions, then release exactly one read.
        begin_xfer(48'h0, 48'h100000, 28'(20 * MX), 100, 100, 0, 1'b0);
        for (int i = 0; i < 40; i++) step();
        check_eq("lim_rd_iss", 64'(rd_iss), 64'(8));
        check_eq("lim_wr_iss", 64'(wr_iss), 64'(8));
        check_eq("lim_rd_valid", 64'(sq_rd_valid), 64'(0));
        force_rd = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        check_eq("lim_rd_one_more", 64'(rd_iss), 64'(9));
        check_eq("lim_wr_same", 64'(wr_iss), 64'(8));
        cq_en = 1'b1;
        cp    = 40;
        finish_xfer(20);

        // Zero length.
        begin_xfer(48'h1234, 48'h5678, 28'd0, 100, 100, 50, 1'b1);
        finish_xfer(0);

        // Randomized transfers, including an address that wraps.
        near_wrap = 48'hFFFF_FFFF_E000;
        for (int k = 0; k < 6; k++) begin
            t = {$urandom(), $urandom()};
            s = (k == 0) ? near_wrap : t[47:0];
            t = {$urandom(), $urandom()};
            d = t[47:0];
            len = int'($urandom_range(20000));
            nchunks = (len + MX - 1) / MX;
            begin_xfer(s, d, 28'(len), int'($urandom_range(100, 30)),
                       int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 1'b1);
            finish_xfer(nchunks);
        end

        // Reset while chunk 2 is being issued, then a clean transfer.
        begin_xfer(48'h2000, 48'h9000, 28'd10000, 100, 100, 50, 1'b1);
        for (int i = 0; i < 50 && !(rd_iss >= 1 && wr_iss >= 1); i++) step();
        do_reset();
        begin_xfer(48'h3000, 48'hA000, 28'd9000, 80, 80, 50, 1'b1);
        finish_xfer(3);

        // Completion with nothing outstanding sets a sticky error.
        @(negedge aclk);
        cq_wr_valid = 1'b1;
        @(negedge aclk);
        cq_wr_valid = 1'b0;
        #1;
        check_eq("err_set", 64'(err), 64'(1));
        repeat (5) @(negedge aclk);
        #1;
        check_eq("err_sticky", 64'(err), 64'(1));
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
